// File: rtl/div_pkg.sv
// Shared encodings for the multicycle divider: DivCtrl commands, FSM states and sizing.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_START  = 2'b01,
    DIV_STARTU = 2'b10,
    DIV_ABORT  = 2'b11
  } div_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0] rem,
  input  logic       dvd_msb,
  input  logic [W:0] dvs,
  output logic [W:0] rem_next,
  output logic       qbit
);

  logic [W+1:0] shifted;

  always_comb begin
    shifted  = {rem, dvd_msb};
    qbit     = (shifted >= {1'b0, dvs});
    rem_next = qbit ? (W+1)'(shifted - {1'b0, dvs}) : shifted[W:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (DIV) producing quotient on LO and remainder on HI.
// Defining DIV_UNSIGNED_EN adds the DivCtrl=10 unsigned start (DIVU).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clck,
  input  logic             reset,
  input  logic [1:0]       DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             DivZeroOP
);

  import div_pkg::*;

  localparam int CNT_BITS = $clog2(WIDTH) + 1;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    dvd_q, dvd_d;
  logic [WIDTH:0]      dvs_q, dvs_d;
  logic [WIDTH:0]      rem_q, rem_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                sign_a_q, sign_a_d;
  logic                neg_q, neg_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                div_zero_q, div_zero_d;

  logic             start_s, start_u, start, abort;
  logic             sign_a, sign_b;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  assign start_s = (DivCtrl == DIV_START);
`ifdef DIV_UNSIGNED_EN
  assign start_u = (DivCtrl == DIV_STARTU);
`else
  assign start_u = 1'b0;
`endif
  assign start = start_s | start_u;
  assign abort = (DivCtrl == DIV_ABORT);

  div_step #(.W(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sign_a_d   = sign_a_q;
    neg_d      = neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    // Unsigned starts force both sign flags low so operands pass through raw.
    sign_a     = start_s & A[WIDTH-1];
    sign_b     = start_s & B[WIDTH-1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (B == '0) begin
            div_zero_d = 1'b1;
          end else begin
            dvd_d    = sign_a ? -A : A;
            dvs_d    = {1'b0, (sign_b ? -B : B)};
            sign_a_d = sign_a;
            neg_d    = sign_a ^ sign_b;
            rem_d    = '0;
            cnt_d    = CNT_BITS'(WIDTH);
            busy_d   = 1'b1;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
          cnt_d = cnt_q - CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          lo_d    = neg_q ? -dvd_q : dvd_q;
          hi_d    = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clck) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      sign_a_q   <= 1'b0;
      neg_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      sign_a_q   <= sign_a_d;
      neg_q      <= neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign HI        = hi_q;
  assign LO        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign DivZeroOP = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divisions against an arithmetic model.
module tb_div_unit;

  import div_pkg::*;

  logic        clck = 1'b0;
  logic        reset;
  logic [1:0]  DivCtrl;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        busy, done, DivZeroOP;

  int total = 0;
  int bad   = 0;

  div_unit dut (
    .clck      (clck),
    .reset     (reset),
    .DivCtrl   (DivCtrl),
    .A         (A),
    .B         (B),
    .HI        (HI),
    .LO        (LO),
    .busy      (busy),
    .done      (done),
    .DivZeroOP (DivZeroOP)
  );

  always #5 clck = ~clck;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive a command for exactly one posedge, then return half a cycle after that edge.
  task automatic applyStimulus(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clck);
    DivCtrl = ctrl;
    A = a;
    B = b;
    @(negedge clck);
    DivCtrl = DIV_IDLE;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic refDiv(input logic [31:0] a, input logic [31:0] b, input bit uns,
                        output logic [31:0] q, output logic [31:0] r);
    longint na, nb;
    na = uns ? longint'(a) : longint'($signed(a));
    nb = uns ? longint'(b) : longint'($signed(b));
    q = 32'(na / nb);
    r = 32'(na % nb);
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 60) begin
      @(negedge clck);
      cycles++;
    end
  endtask

  task automatic countDone(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clck);
      if (done === 1'b1) pulses++;
    end
  endtask

  task automatic runDiv(input string tag, input logic [1:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input bit uns);
    logic [31:0] q, r;
    int cyc;
    refDiv(a, b, uns, q, r);
    applyStimulus(ctrl, a, b);
    checkOutput({tag, " busy"}, {31'b0, busy}, 32'd1);
    waitDone(cyc);
    checkOutput({tag, " latency"}, 32'(cyc), 32'd33);
    checkOutput({tag, " LO"}, LO, q);
    checkOutput({tag, " HI"}, HI, r);
    checkOutput({tag, " busy_end"}, {31'b0, busy}, 32'd0);
    @(negedge clck);
    checkOutput({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    checkOutput({tag, " LO_hold"}, LO, q);
  endtask

  initial begin
    int pulses;
    int cyc;
    logic [31:0] a, b, prev_hi, prev_lo;

    reset = 1'b0;
    DivCtrl = DIV_IDLE;
    A = '0;
    B = '0;
    repeat (3) @(negedge clck);
    checkOutput("rst HI", HI, 32'd0);
    checkOutput("rst LO", LO, 32'd0);
    checkOutput("rst busy", {31'b0, busy}, 32'd0);
    checkOutput("rst done", {31'b0, done}, 32'd0);
    checkOutput("rst dz", {31'b0, DivZeroOP}, 32'd0);
    reset = 1'b1;

    runDiv("100/7", DIV_START, 32'd100, 32'd7, 1'b0);
    checkOutput("100/7 LO const", LO, 32'd14);
    checkOutput("100/7 HI const", HI, 32'd2);

    // Reset in the middle of a running division
    applyStimulus(DIV_START, 32'd100, 32'd7);
    repeat (5) @(negedge clck);
    reset = 1'b0;
    repeat (2) @(negedge clck);
    checkOutput("midrst HI", HI, 32'd0);
    checkOutput("midrst LO", LO, 32'd0);
    checkOutput("midrst busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    countDone(40, pulses);
    checkOutput("midrst no_done", 32'(pulses), 32'd0);

    runDiv("-7/2", DIV_START, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkOutput("-7/2 LO const", LO, 32'hFFFF_FFFD);
    checkOutput("-7/2 HI const", HI, 32'hFFFF_FFFF);
    runDiv("min/-1", DIV_START, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checkOutput("min/-1 LO const", LO, 32'h8000_0000);
    checkOutput("min/-1 HI const", HI, 32'd0);
    runDiv("5/-2", DIV_START, 32'd5, 32'hFFFF_FFFE, 1'b0);
    checkOutput("5/-2 LO const", LO, 32'hFFFF_FFFE);
    checkOutput("5/-2 HI const", HI, 32'd1);

    // Divide by zero keeps the previous result
    applyStimulus(DIV_START, 32'd42, 32'd0);
    checkOutput("dz pulse", {31'b0, DivZeroOP}, 32'd1);
    checkOutput("dz busy", {31'b0, busy}, 32'd0);
    @(negedge clck);
    checkOutput("dz pulse_end", {31'b0, DivZeroOP}, 32'd0);
    checkOutput("dz HI hold", HI, 32'd1);
    checkOutput("dz LO hold", LO, 32'hFFFF_FFFE);

    // Restart while busy is ignored; the original division completes on time
    applyStimulus(DIV_START, 32'd1000, 32'd3);
    repeat (3) @(negedge clck);
    applyStimulus(DIV_START, 32'd77, 32'd5);
    waitDone(cyc);
    checkOutput("restart latency", 32'(cyc), 32'd28);
    checkOutput("restart LO", LO, 32'd333);
    checkOutput("restart HI", HI, 32'd1);

    // Abort in RUN at k+10, with a zero-divisor start at k+5 in between
    applyStimulus(DIV_START, 32'd12345, 32'd6);
    repeat (3) @(negedge clck);
    applyStimulus(DIV_START, 32'd9, 32'd0);
    checkOutput("busy dz_ignored", {31'b0, DivZeroOP}, 32'd0);
    repeat (3) @(negedge clck);
    applyStimulus(DIV_ABORT, 32'd0, 32'd0);
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort done", {31'b0, done}, 32'd0);
    checkOutput("abort HI", HI, 32'd1);
    checkOutput("abort LO", LO, 32'd333);
    countDone(40, pulses);
    checkOutput("abort no_done", 32'(pulses), 32'd0);

    // Abort landing on the FIX cycle
    applyStimulus(DIV_START, 32'd50, 32'd4);
    repeat (31) @(negedge clck);
    applyStimulus(DIV_ABORT, 32'd0, 32'd0);
    checkOutput("fixabort done", {31'b0, done}, 32'd0);
    checkOutput("fixabort busy", {31'b0, busy}, 32'd0);
    checkOutput("fixabort LO", LO, 32'd333);

    applyStimulus(DIV_ABORT, 32'd1, 32'd1);
    checkOutput("idleabort busy", {31'b0, busy}, 32'd0);
    checkOutput("idleabort HI", HI, 32'd1);

`ifdef DIV_UNSIGNED_EN
    runDiv("divu", DIV_STARTU, 32'hFFFF_FFFF, 32'd16, 1'b1);
    checkOutput("divu LO const", LO, 32'h0FFF_FFFF);
    checkOutput("divu HI const", HI, 32'd15);
`else
    applyStimulus(DIV_STARTU, 32'hFFFF_FFFF, 32'd0);
    checkOutput("startu hold busy", {31'b0, busy}, 32'd0);
    checkOutput("startu hold dz", {31'b0, DivZeroOP}, 32'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: b = 32'hFFFF_FFFF;
      endcase
      if (b == 32'd0) b = 32'd3;
      runDiv($sformatf("rand%0d", i), DIV_START, a, b, 1'b0);
    end

    prev_hi = HI;
    prev_lo = LO;
    repeat (5) @(negedge clck);
    checkOutput("final HI hold", HI, prev_hi);
    checkOutput("final LO hold", LO, prev_lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
